// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares one register-file write port between the WB stage and a 2-deep aux queue with starvation forcing.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_result,
    input  logic        aux_valid,
    input  logic [3:0]  aux_dest,
    input  logic [31:0] aux_result,
    output logic        aux_ready,
    output logic        writeBackEn,
    output logic [3:0]  Dest_wb,
    output logic [31:0] Result_WB,
    output logic        wb_stall,
    output logic [15:0] aux_pending
);
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;
    state_t        state, state_n;
    logic [CW-1:0] blk;
    logic [1:0]    v;
    logic [3:0]    dst [2];
    logic [31:0]   dat [2];
    logic          grant_aux, grant_wb, push, pop, slot, empty_n;
    assign grant_aux   = !rst && ((state == FORCE) || (!wb_en && v[0]));
    assign grant_wb    = !rst && (state != FORCE) && wb_en;
    assign aux_ready   = !v[1];
    assign push        = aux_valid && aux_ready;
    assign pop         = grant_aux;
    // slot 0 is always the head; a pop shifts slot 1 down before the push lands
    assign slot        = pop ? v[1] : v[0];
    assign empty_n     = !slot && !push;
    assign wb_stall    = (state == FORCE);
    assign writeBackEn = grant_aux || grant_wb;
    assign Dest_wb     = grant_aux ? dst[0] : grant_wb ? wb_dest : 4'd0;
    assign Result_WB   = grant_aux ? dat[0] : grant_wb ? wb_result : 32'd0;
    assign aux_pending = (v[0] ? 16'(1) << dst[0] : 16'd0) | (v[1] ? 16'(1) << dst[1] : 16'd0);
    always_comb
        state_n = empty_n ? IDLE :
                  (state == WAIT && wb_en && blk == CW'(STARVE_LIMIT - 1)) ? FORCE : WAIT;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            blk    <= '0;
            v      <= '0;
            dst[0] <= '0;
            dst[1] <= '0;
            dat[0] <= '0;
            dat[1] <= '0;
        end else begin
            state <= state_n;
            blk   <= (grant_aux || empty_n) ? '0 : (state == WAIT && wb_en) ? blk + 1'b1 : blk;
            if (pop) begin
                v      <= {1'b0, v[1]};
                dst[0] <= dst[1];
                dat[0] <= dat[1];
            end
            if (push) begin
                v[slot]   <= 1'b1;
                dst[slot] <= aux_dest;
                dat[slot] <= aux_result;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of grant muxing, queueing, starvation forcing and reset.
module tb_regfile_write_arbiter;
    logic        clk = 0, rst = 1;
    logic        wb_en = 0, aux_valid = 0;
    logic [3:0]  wb_dest = 0, aux_dest = 0;
    logic [31:0] wb_result = 0, aux_result = 0;
    logic        aux_ready, writeBackEn, wb_stall;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_WB;
    logic [15:0] aux_pending;
    int checks = 0, errors = 0;

    regfile_write_arbiter dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_dest(wb_dest), .wb_result(wb_result),
        .aux_valid(aux_valid), .aux_dest(aux_dest), .aux_result(aux_result),
        .aux_ready(aux_ready), .writeBackEn(writeBackEn), .Dest_wb(Dest_wb),
        .Result_WB(Result_WB), .wb_stall(wb_stall), .aux_pending(aux_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] wd, input logic [31:0] wr,
                         input logic av, input logic [3:0] ad, input logic [31:0] ar);
        @(negedge clk);
        wb_en = we; wb_dest = wd; wb_result = wr;
        aux_valid = av; aux_dest = ad; aux_result = ar;
        #1;
    endtask

    task automatic out(input string tag, input logic we, input logic [3:0] d, input logic [31:0] r,
                       input logic st, input logic rdy, input logic [15:0] pend);
        chk({tag, ".wbe"}, 32'(writeBackEn), 32'(we));
        chk({tag, ".dest"}, 32'(Dest_wb), 32'(d));
        chk({tag, ".data"}, Result_WB, r);
        chk({tag, ".stall"}, 32'(wb_stall), 32'(st));
        chk({tag, ".ready"}, 32'(aux_ready), 32'(rdy));
        chk({tag, ".pend"}, 32'(aux_pending), 32'(pend));
    endtask

    initial begin
        wb_en = 1; wb_dest = 3; wb_result = 32'h55;
        #2 out("reset", 0, 0, 0, 0, 1, 0);
        @(negedge clk); rst = 0;
        // WB only
        drive(1, 3, 32'hDEADBEEF, 0, 0, 0);  out("wb_only", 1, 3, 32'hDEADBEEF, 0, 1, 0);
        // aux into idle queue
        drive(0, 0, 0, 1, 5, 32'h12);        out("aux_acc", 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);             out("aux_wr", 1, 5, 32'h12, 0, 1, 16'h0020);
        drive(0, 0, 0, 0, 0, 0);             out("aux_done", 0, 0, 0, 0, 1, 0);
        // fill the queue while WB holds the port, then starvation forces the head
        drive(1, 1, 32'hA, 1, 7, 32'h70);    out("fill1", 1, 1, 32'hA, 0, 1, 0);
        drive(1, 1, 32'hA, 1, 15, 32'hF0);   out("fill2", 1, 1, 32'hA, 0, 1, 16'h0080);
        drive(1, 1, 32'hA, 1, 2, 32'h22);    out("full", 1, 1, 32'hA, 0, 0, 16'h8080);
        drive(1, 1, 32'hA, 0, 0, 0);         out("no_third", 1, 1, 32'hA, 0, 0, 16'h8080);
        drive(1, 1, 32'hB, 0, 0, 0);         out("force1", 1, 7, 32'h70, 1, 0, 16'h8080);
        drive(0, 0, 0, 0, 0, 0);             out("drain15", 1, 15, 32'hF0, 0, 1, 16'h8000);
        drive(0, 0, 0, 0, 0, 0);             out("drained", 0, 0, 0, 0, 1, 0);
        // single entry starvation: three blocked cycles, then one forced cycle
        drive(1, 2, 32'h200, 1, 9, 32'h99);  out("st_acc", 1, 2, 32'h200, 0, 1, 0);
        drive(1, 2, 32'h201, 0, 0, 0);       out("st_b1", 1, 2, 32'h201, 0, 1, 16'h0200);
        drive(1, 2, 32'h202, 0, 0, 0);       out("st_b2", 1, 2, 32'h202, 0, 1, 16'h0200);
        drive(1, 2, 32'h203, 0, 0, 0);       out("st_b3", 1, 2, 32'h203, 0, 1, 16'h0200);
        drive(1, 2, 32'h204, 0, 0, 0);       out("st_force", 1, 9, 32'h99, 1, 1, 16'h0200);
        drive(1, 2, 32'h205, 0, 0, 0);       out("st_after", 1, 2, 32'h205, 0, 1, 0);
        // duplicate destinations, accept while draining keeps one entry
        drive(1, 0, 32'h1, 1, 4, 32'h1);     out("dup_acc", 1, 0, 32'h1, 0, 1, 0);
        drive(0, 0, 0, 1, 4, 32'h2);         out("dup_wr1", 1, 4, 32'h1, 0, 1, 16'h0010);
        drive(0, 0, 0, 0, 0, 0);             out("dup_wr2", 1, 4, 32'h2, 0, 1, 16'h0010);
        drive(0, 0, 0, 0, 0, 0);             out("dup_done", 0, 0, 0, 0, 1, 0);
        // reset with two queued entries discards them
        drive(1, 1, 32'h3, 1, 6, 32'h66);    out("rq1", 1, 1, 32'h3, 0, 1, 0);
        drive(1, 1, 32'h3, 1, 8, 32'h88);    out("rq2", 1, 1, 32'h3, 0, 1, 16'h0040);
        drive(1, 1, 32'h3, 0, 0, 0);         out("rq_full", 1, 1, 32'h3, 0, 0, 16'h0140);
        rst = 1;
        #1                                   out("rst_mid", 0, 0, 0, 0, 1, 0);
        @(negedge clk); rst = 0;
        wb_en = 0; aux_valid = 1; aux_dest = 11; aux_result = 32'hB;
        #1                                   out("rel_acc", 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);             out("rel_wr", 1, 11, 32'hB, 0, 1, 16'h0800);
        drive(0, 0, 0, 0, 0, 0);             out("rel_idle", 0, 0, 0, 0, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 3, meaning consecutive blocked cycles of the queued aux head before the arbiter forces an aux write.
REQ-002 The block SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 The block SHALL have port wb_en  input  1  writeback-stage write request; it cannot be back-pressured except via wb_stall.
REQ-005 The block SHALL have port wb_dest  input  4  writeback destination register.
REQ-006 The block SHALL have port wb_result  input  32  writeback data.
REQ-007 The block SHALL have port aux_valid  input  1  multi-cycle unit write request.
REQ-008 The block SHALL have port aux_dest  input  4  aux destination register.
REQ-009 The block SHALL have port aux_result  input  32  aux data.
REQ-010 The block SHALL have port aux_ready  output  1  aux entry accepted when aux_valid and aux_ready are both high at a rising edge.
REQ-011 The block SHALL have port writeBackEn  output  1  register-file write enable.
REQ-012 The block SHALL have port Dest_wb  output  4  register-file write address.
REQ-013 The block SHALL have port Result_WB  output  32  register-file write data.
REQ-014 The block SHALL have port wb_stall  output  1  pipeline holds the WB stage this cycle; wb_en ignored.
REQ-015 The block SHALL have port aux_pending  output  16  bit n is high while any queued aux entry targets register n.

Function
REQ-016 Aux entries SHALL be held in a 2-entry FIFO, in order; aux_ready = FIFO not full, combinational.
REQ-017 A full FIFO SHALL NOT accept, even in a cycle when it drains.
REQ-018 Simultaneous accept and drain on a non-full FIFO SHALL leave occupancy unchanged.
REQ-019 The FSM SHALL have the states IDLE (FIFO empty), WAIT (FIFO non-empty) and FORCE; wb_stall = (state == FORCE), decoded from registered state only.
REQ-020 Grant rule: in FORCE, the FIFO head SHALL be granted; otherwise wb_en=1 grants WB; otherwise a non-empty FIFO grants its head; otherwise there is no write.
REQ-021 Output muxing SHALL be combinational: writeBackEn=1 and Dest_wb/Result_WB take the granted source's values in the same cycle; with no grant, writeBackEn=0 and Dest_wb/Result_WB=0.
REQ-022 Granting the head SHALL pop it at the next rising edge; the minimum aux latency is acceptance edge to the write in the following cycle.
REQ-023 Blocked counter: it SHALL increment when state is WAIT and wb_en=1, and clear on any head grant or on entering IDLE.
REQ-024 Transitions: IDLE->WAIT on accept. WAIT->FORCE when the counter reaches STARVE_LIMIT. WAIT->IDLE when a pop empties the FIFO with no accept. FORCE->WAIT if entries remain after the pop, else FORCE->IDLE; FORCE lasts exactly one cycle.
REQ-025 Destination 15 SHALL be handled like any other destination.
REQ-026 aux_pending SHALL be the OR of one-hot(dest) over valid FIFO entries, updated from registered state.
REQ-027 Duplicate destinations in the FIFO SHALL both be written in order; the bit clears only when no entry holds that destination.
REQ-028 WB and aux writes to the same register SHALL NOT be reordered by the block; hazard logic uses aux_pending.

Reset
REQ-029 While rst=1, regardless of clk: FIFO empty, state IDLE, counter 0, aux_ready=1, writeBackEn=0, Dest_wb=0, Result_WB=0, wb_stall=0, aux_pending=0.
REQ-030 Reset asserted mid-operation SHALL discard queued entries without writing them.
REQ-031 The first accept SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-032 WB only: wb_en=1, dest=3, data=0xDEADBEEF -> same cycle writeBackEn=1, Dest_wb=3, Result_WB=0xDEADBEEF; wb_stall=0.
REQ-033 Aux into idle: accept dest=5, data=0x12 with wb_en=0 -> next cycle writeBackEn=1, Dest_wb=5; aux_pending=0x0020 for exactly that cycle, then 0.
REQ-034 Fill: two accepts while wb_en=1 -> aux_ready=0, aux_pending shows both bits; a third aux_valid is not accepted.
REQ-035 Starvation: one entry queued, wb_en held 1 -> after 3 blocked cycles wb_stall=1 for one cycle with the aux entry written; the WB data is not written that cycle.
REQ-036 Reset: rst pulsed with 2 entries queued -> immediate aux_ready=1, aux_pending=0; no aux write occurs after release.
